cpu_launch_seq: RTL and testbench
=================================

Name: cpu_launch_seq

Overview:
- Upstream sequencer for the lab3 CPU core.
- Holds a small table of program start addresses and, on one go pulse, runs each program in turn: it drives start_i/start_addr into the core, waits for the core's done, and measures cycles per program.
- Replaces hand-sequenced start pulses, so a batch of programs (e.g. entries 0, 93, 138) runs back-to-back in hardware.

Parameters:
- NUM_PROGS, 4, number of address-table entries (1..16).
- ADDR_W, 8, width of a CPU start address.
- CNT_W, 16, width of the per-program cycle counter.
- MAX_CYCLES, 16'hFFFF, timeout limit for one program run, in clock_i cycles.

Ports:
- clock_i  in  1  single system clock; rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- wr_en_i  in  1  write one table entry; ignored while busy_o=1.
- wr_idx_i  in  $clog2(NUM_PROGS)  table index to write.
- wr_addr_i  in  ADDR_W  start address to store.
- num_i  in  $clog2(NUM_PROGS)+1  number of entries to run (0 = none); sampled on go_i.
- go_i  in  1  one-cycle start of a batch; ignored while busy_o=1.
- done_i  in  1  CPU done level, from the core's done output.
- start_o  out  1  to CPU start_i; one-cycle pulse.
- start_addr_o  out  ADDR_W  to CPU start_addr; held stable from the launch cycle to the end of that run.
- busy_o  out  1  batch in progress.
- prog_idx_o  out  $clog2(NUM_PROGS)  index of the current or last program.
- cycles_o  out  CNT_W  cycle count of the last completed program.
- cycles_vld_o  out  1  one-cycle pulse when cycles_o updates.
- batch_done_o  out  1  one-cycle pulse at the end of a batch.
- timeout_o  out  1  sticky; set on timeout, cleared by the next accepted go_i.

Behaviour:
- Reset (asynchronous, reset_n_i=0):
  - All outputs 0; state IDLE.
  - Table entries reset to 0.
  - Reset mid-run abandons the batch immediately; start_o deasserts in the same instant.
- FSM states: IDLE, LAUNCH, ARM, RUN, LOG, FINISH.
- IDLE:
  - wr_en_i writes table[wr_idx_i].
  - If go_i && num_i!=0: latch num_i, idx=0, clear timeout_o, busy_o=1, go to LAUNCH.
  - If go_i && num_i==0: pulse batch_done_o for one cycle; busy_o stays 0.
  - If go_i and wr_en_i arrive together: the write completes first; go_i uses the updated table.
- LAUNCH (1 cycle):
  - start_o=1; start_addr_o=table[idx]; counter=0; go to ARM.
- ARM:
  - The core's done is a level and may still be high from the previous run. Done is not trusted until it has been seen low.
  - Counter increments every cycle.
  - done_i==0 -> go to RUN.
- RUN:
  - Counter increments every cycle.
  - done_i==1 -> go to LOG.
- Cycle count: number of cycles from LAUNCH up to, but not including, the cycle in which LOG is entered. The counter saturates at all-ones.
- Timeout: in ARM or RUN, counter==MAX_CYCLES -> set timeout_o, go to FINISH. The current program is not logged.
- LOG (1 cycle):
  - cycles_o=counter; cycles_vld_o=1; prog_idx_o=idx.
  - If idx==num-1 -> FINISH; else idx+1 -> LAUNCH.
- FINISH (1 cycle):
  - batch_done_o=1; busy_o=0 from the next cycle; go to IDLE.
- busy_o is 1 in every state except IDLE.
- prog_idx_o tracks idx from LAUNCH onward.
- Index wrap: num_i > NUM_PROGS is clamped to NUM_PROGS.
- start_o is never asserted in consecutive cycles. The minimum spacing between start pulses is 4 cycles.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W constant (shared with the CPU core);
  - the state enum launch_state_t {IDLE, LAUNCH, ARM, RUN, LOG, FINISH};
  - a saturating-counter width constant.
- One sub-module is natural: launch_addr_tbl, the register file for the NUM_PROGS x ADDR_W table (write port plus combinational read by idx).

Test Plan:
- Table {0,93,138}, num_i=3, go_i; CPU model raises done 20/35/12 cycles after start -> three start_o pulses with addrs 0,93,138 in order; cycles_o = 20, 35, 12 (±1 per the counting rule); batch_done_o pulses once; busy_o falls after it.
- done_i held high before go_i and after each run (stale done) -> no early completion; LOG is reached only after done_i low then high.
- num_i=1, CPU never raises done, MAX_CYCLES=50 -> timeout_o=1 at cycle 50; no cycles_vld_o; batch_done_o pulses; the next go_i clears timeout_o.
- go_i and wr_en_i during busy_o=1 -> both ignored; table unchanged; the batch continues.
- reset_n_i low mid-RUN -> all outputs 0 immediately; go_i after release runs the batch from index 0 with the table back at 0.
- num_i=0 -> batch_done_o pulses; no start_o; busy_o stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Definitions shared between the lab3 CPU core and its launch sequencer.
package cpu_pkg;

   localparam int CPU_ADDR_W   = 8;
   localparam int LAUNCH_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      ARM,
      RUN,
      LOG,
      FINISH
   } launch_state_t;

endpackage

// File: rtl/launch_addr_tbl.sv
// Program start-address table: one synchronous write port, combinational read.
module launch_addr_tbl #(
   parameter int ADDR_W = 8,
   parameter int IDX_W  = 2
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [ADDR_W-1:0] rd_addr_o
);

   // Full power-of-two depth keeps indexing in range; entries past NUM_PROGS
   // are never read because the run count is clamped.
   localparam int DEPTH = 1 << IDX_W;

   logic [ADDR_W-1:0] r_tbl [DEPTH];

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < DEPTH; i++) r_tbl[i] <= '0;
      end else if (wr_en_i) begin
         r_tbl[wr_idx_i] <= wr_addr_i;
      end
   end

   assign rd_addr_o = r_tbl[rd_idx_i];

endmodule

// File: rtl/cpu_launch_seq.sv
// Batch launcher for the lab3 CPU core: starts each table entry in turn,
// waits for the core's done level and reports cycles per program.
//
// state  | meaning
// IDLE   | waiting for go_i; table writes accepted
// LAUNCH | start pulse to the core with table[idx]
// ARM    | counting; waiting for a possibly stale done to drop
// RUN    | counting; waiting for done to rise
// LOG    | publish cycle count; advance idx or finish
// FINISH | batch_done pulse, back to IDLE
module cpu_launch_seq
   import cpu_pkg::*;
#(
   parameter int               NUM_PROGS  = 4,
   parameter int               ADDR_W     = CPU_ADDR_W,
   parameter int               CNT_W      = LAUNCH_CNT_W,
   parameter logic [CNT_W-1:0] MAX_CYCLES = {CNT_W{1'b1}},
   localparam int              IDX_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
   localparam int              NUM_W      = $clog2(NUM_PROGS) + 1
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [NUM_W-1:0]  num_i,
   input  logic              go_i,
   input  logic              done_i,
   output logic              start_o,
   output logic [ADDR_W-1:0] start_addr_o,
   output logic              busy_o,
   output logic [IDX_W-1:0]  prog_idx_o,
   output logic [CNT_W-1:0]  cycles_o,
   output logic              cycles_vld_o,
   output logic              batch_done_o,
   output logic              timeout_o
);

   launch_state_t     r_state, w_nxt;
   logic [NUM_W-1:0]  r_num;
   logic [IDX_W-1:0]  r_idx;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_cycles;
   logic              r_cycles_vld;
   logic              r_bd_zero;
   logic              r_timeout;
   logic [ADDR_W-1:0] r_addr_hold;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [NUM_W-1:0]  w_num_clamp;
   logic              w_last;
   logic              w_tmo;
   logic              w_wr_en;

   assign w_wr_en     = wr_en_i && (r_state == IDLE);
   assign w_num_clamp = (num_i > NUM_W'(NUM_PROGS)) ? NUM_W'(NUM_PROGS) : num_i;
   assign w_last      = (NUM_W'(r_idx) == r_num - NUM_W'(1));
   assign w_tmo       = (r_cnt == MAX_CYCLES);

   launch_addr_tbl #(
      .ADDR_W (ADDR_W),
      .IDX_W  (IDX_W)
   ) u_tbl (
      .clock_i   (clock_i),
      .reset_n_i (reset_n_i),
      .wr_en_i   (w_wr_en),
      .wr_idx_i  (wr_idx_i),
      .wr_addr_i (wr_addr_i),
      .rd_idx_i  (r_idx),
      .rd_addr_o (w_rd_addr)
   );

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) r_state <= IDLE;
      else            r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    if (go_i && (num_i != '0)) w_nxt = LAUNCH;
         LAUNCH:  w_nxt = ARM;
         ARM:     if (w_tmo) w_nxt = FINISH; else if (!done_i) w_nxt = RUN;
         RUN:     if (w_tmo) w_nxt = FINISH; else if (done_i) w_nxt = LOG;
         LOG:     w_nxt = w_last ? FINISH : LAUNCH;
         FINISH:  w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   // r_cnt holds the cycles elapsed since LAUNCH, the LAUNCH cycle included,
   // so its value in the LOG cycle is the reported program length.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_num        <= '0;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_cycles     <= '0;
         r_cycles_vld <= 1'b0;
         r_bd_zero    <= 1'b0;
         r_timeout    <= 1'b0;
         r_addr_hold  <= '0;
      end else begin
         r_cycles_vld <= 1'b0;
         r_bd_zero    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (go_i) begin
                  if (num_i != '0) begin
                     r_num     <= w_num_clamp;
                     r_idx     <= '0;
                     r_timeout <= 1'b0;
                  end else begin
                     r_bd_zero <= 1'b1;
                  end
               end
            end
            LAUNCH: begin
               r_cnt       <= CNT_W'(1);
               r_addr_hold <= w_rd_addr;
            end
            ARM, RUN: begin
               if (w_tmo)              r_timeout <= 1'b1;
               else if (r_cnt != '1)   r_cnt     <= r_cnt + CNT_W'(1);
            end
            LOG: begin
               r_cycles     <= r_cnt;
               r_cycles_vld <= 1'b1;
               if (!w_last) r_idx <= r_idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign start_o      = (r_state == LAUNCH);
   assign start_addr_o = start_o ? w_rd_addr : r_addr_hold;
   assign busy_o       = (r_state != IDLE);
   assign prog_idx_o   = r_idx;
   assign cycles_o     = r_cycles;
   assign cycles_vld_o = r_cycles_vld;
   assign batch_done_o = (r_state == FINISH) || r_bd_zero;
   assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_cpu_launch_seq.sv
// Directed bench for cpu_launch_seq with a behavioural CPU done model.
module tb_cpu_launch_seq;

   logic        clock_i;
   logic        reset_n_i;
   logic        wr_en_i;
   logic [1:0]  wr_idx_i;
   logic [7:0]  wr_addr_i;
   logic [2:0]  num_i;
   logic        go_i;
   logic        done_i;
   logic        start_o;
   logic [7:0]  start_addr_o;
   logic        busy_o;
   logic [1:0]  prog_idx_o;
   logic [15:0] cycles_o;
   logic        cycles_vld_o;
   logic        batch_done_o;
   logic        timeout_o;

   cpu_launch_seq #(
      .NUM_PROGS  (4),
      .ADDR_W     (8),
      .CNT_W      (16),
      .MAX_CYCLES (16'd50)
   ) dut (
      .clock_i      (clock_i),
      .reset_n_i    (reset_n_i),
      .wr_en_i      (wr_en_i),
      .wr_idx_i     (wr_idx_i),
      .wr_addr_i    (wr_addr_i),
      .num_i        (num_i),
      .go_i         (go_i),
      .done_i       (done_i),
      .start_o      (start_o),
      .start_addr_o (start_addr_o),
      .busy_o       (busy_o),
      .prog_idx_o   (prog_idx_o),
      .cycles_o     (cycles_o),
      .cycles_vld_o (cycles_vld_o),
      .batch_done_o (batch_done_o),
      .timeout_o    (timeout_o)
   );

   initial begin
      clock_i = 1'b0;
      forever #5 clock_i = ~clock_i;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // monitor: records launches, logged counts and batch ends at negedge
   int cyc = 0;
   int st_addr[$];
   int st_idx[$];
   int st_t[$];
   int cyc_val[$];
   int bd_n = 0;
   int t_start = 0;
   int t_bd = 0;
   int last_st = -100;
   int spacing_err = 0;
   bit busy_seen = 0;

   always @(negedge clock_i) begin
      cyc++;
      if (busy_o) busy_seen = 1;
      if (start_o) begin
         if (cyc - last_st < 4) spacing_err++;
         last_st = cyc;
         t_start = cyc;
         st_addr.push_back(int'(start_addr_o));
         st_idx.push_back(int'(prog_idx_o));
         st_t.push_back(cyc);
      end
      if (cycles_vld_o) cyc_val.push_back(int'(cycles_o));
      if (batch_done_o) begin
         bd_n++;
         t_bd = cyc;
      end
   end

   // CPU model: done stays at its old level for m_stale cycles after start,
   // then low, then high from m_dur cycles after start (never if no entry).
   int  dur_q[$];
   int  m_stale = 0;
   bit  m_active = 0;
   int  m_k = 0;
   int  m_dur = -1;

   initial begin
      forever begin
         @(posedge clock_i);
         #1;
         if (start_o) begin
            m_active = 1;
            m_k = 0;
            m_dur = (dur_q.size() > 0) ? dur_q.pop_front() : -1;
         end else if (m_active) begin
            m_k++;
         end
         if (m_active) begin
            if (m_dur >= 0 && m_k >= m_dur) done_i = 1'b1;
            else if (m_k >= m_stale)        done_i = 1'b0;
         end
      end
   end

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic clr_mon();
      st_addr.delete();
      st_idx.delete();
      st_t.delete();
      cyc_val.delete();
      bd_n = 0;
      last_st = -100;
      spacing_err = 0;
      busy_seen = 0;
   endtask

   task automatic nsamp();
      @(negedge clock_i);
      #1;
   endtask

   task automatic wr(input logic [1:0] idx, input logic [7:0] addr);
      @(posedge clock_i); #1;
      wr_en_i = 1'b1; wr_idx_i = idx; wr_addr_i = addr;
      @(posedge clock_i); #1;
      wr_en_i = 1'b0;
   endtask

   task automatic go(input logic [2:0] n);
      @(posedge clock_i); #1;
      go_i = 1'b1; num_i = n;
      @(posedge clock_i); #1;
      go_i = 1'b0;
   endtask

   task automatic wait_bd(input string tag, input int budget);
      int k = 0;
      while (bd_n < 1 && k < budget) begin
         nsamp();
         k++;
      end
      chk(tag, bd_n, 1);
   endtask

   task automatic wait_start(input string tag, input int budget);
      int k = 0;
      while (st_addr.size() < 1 && k < budget) begin
         nsamp();
         k++;
      end
      chk(tag, st_addr.size(), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n_i = 1'b0;
      wr_en_i   = 1'b0;
      wr_idx_i  = '0;
      wr_addr_i = '0;
      num_i     = '0;
      go_i      = 1'b0;
      done_i    = 1'b1;
      repeat (3) nsamp();
      chk("rst_busy",   busy_o, 0);
      chk("rst_start",  start_o, 0);
      chk("rst_bd",     batch_done_o, 0);
      chk("rst_tmo",    timeout_o, 0);
      chk("rst_cycles", cycles_o, 0);
      reset_n_i = 1'b1;

      // batch of three with stale done before and after each run
      wr(2'd0, 8'd0);
      wr(2'd1, 8'd93);
      wr(2'd2, 8'd138);
      wr(2'd3, 8'd77);
      clr_mon();
      m_stale = 3;
      dur_q = '{20, 35, 12};
      go(3'd3);
      wait_start("b1_start", 20);
      @(posedge clock_i); #1;
      wr_en_i = 1'b1; wr_idx_i = 2'd1; wr_addr_i = 8'hAA; go_i = 1'b1; num_i = 3'd1;
      @(posedge clock_i); #1;
      wr_en_i = 1'b0; go_i = 1'b0;
      wait_bd("b1_done", 300);
      nsamp();
      chk("b1_busy_after", busy_o, 0);
      repeat (5) nsamp();
      chk("b1_bd_once",  bd_n, 1);
      chk("b1_nstart",   st_addr.size(), 3);
      chk("b1_addr0",    qget(st_addr, 0), 0);
      chk("b1_addr1",    qget(st_addr, 1), 93);
      chk("b1_addr2",    qget(st_addr, 2), 138);
      chk("b1_cyc0",     qget(cyc_val, 0), 21);
      chk("b1_cyc1",     qget(cyc_val, 1), 36);
      chk("b1_cyc2",     qget(cyc_val, 2), 13);
      chk("b1_nvld",     cyc_val.size(), 3);
      chk("b1_prog_idx", prog_idx_o, 2);
      chk("b1_tmo",      timeout_o, 0);
      chk("b1_spacing",  spacing_err, 0);

      // go with a simultaneous write, num clamped from 7 to 4
      clr_mon();
      dur_q = '{5, 5, 5, 5};
      @(posedge clock_i); #1;
      wr_en_i = 1'b1; wr_idx_i = 2'd0; wr_addr_i = 8'h55; go_i = 1'b1; num_i = 3'd7;
      @(posedge clock_i); #1;
      wr_en_i = 1'b0; go_i = 1'b0;
      wait_bd("b2_done", 200);
      chk("b2_nstart",   st_addr.size(), 4);
      chk("b2_addr0",    qget(st_addr, 0), 8'h55);
      chk("b2_addr1",    qget(st_addr, 1), 93);
      chk("b2_addr3",    qget(st_addr, 3), 77);
      chk("b2_idx3",     qget(st_idx, 3), 3);
      chk("b2_cyc3",     qget(cyc_val, 3), 6);
      chk("b2_prog_idx", prog_idx_o, 3);

      // timeout: the core never raises done
      clr_mon();
      m_stale = 0;
      dur_q.delete();
      go(3'd1);
      wait_bd("to_done", 200);
      chk("to_latency", t_bd - t_start, 51);
      chk("to_flag",    timeout_o, 1);
      chk("to_nvld",    cyc_val.size(), 0);
      nsamp();
      chk("to_busy_after", busy_o, 0);

      // empty batch
      clr_mon();
      go(3'd0);
      repeat (3) nsamp();
      chk("n0_bd",     bd_n, 1);
      chk("n0_nstart", st_addr.size(), 0);
      chk("n0_busy",   busy_seen, 0);

      // next accepted go clears timeout
      clr_mon();
      dur_q = '{8};
      go(3'd1);
      wait_start("tc_start", 10);
      chk("tc_tmo_clr", timeout_o, 0);
      wait_bd("tc_done", 100);
      chk("tc_cyc", qget(cyc_val, 0), 9);

      // reset in the middle of RUN
      clr_mon();
      dur_q = '{30};
      go(3'd2);
      wait_start("rr_start", 10);
      repeat (10) nsamp();
      reset_n_i = 1'b0;
      m_active = 0;
      #1;
      chk("rr_busy",   busy_o, 0);
      chk("rr_start",  start_o, 0);
      chk("rr_addr",   start_addr_o, 0);
      chk("rr_cycles", cycles_o, 0);
      chk("rr_vld",    cycles_vld_o, 0);
      chk("rr_bd",     batch_done_o, 0);
      done_i = 1'b0;
      repeat (2) nsamp();
      reset_n_i = 1'b1;

      // after reset: table back at zero, back-to-back minimum spacing
      clr_mon();
      dur_q = '{2, 2, 2};
      go(3'd3);
      wait_bd("ar_done", 100);
      chk("ar_nstart", st_addr.size(), 3);
      chk("ar_addr0",  qget(st_addr, 0), 0);
      chk("ar_addr1",  qget(st_addr, 1), 0);
      chk("ar_addr2",  qget(st_addr, 2), 0);
      chk("ar_idx0",   qget(st_idx, 0), 0);
      chk("ar_idx2",   qget(st_idx, 2), 2);
      chk("ar_cyc0",   qget(cyc_val, 0), 3);
      chk("ar_gap",    qget(st_t, 1) - qget(st_t, 0), 4);
      chk("ar_spacing", spacing_err, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
